reg_slice_chain: RTL

REG_SLICE_CHAIN -- requirements
Module: reg_slice_chain

---
 rtl/reg_slice_chain.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reg_slice_chain.sv
// Cascade of STAGES valid/ready register slices.
// SKID=0: one register per stage, ready ripples back combinationally.
// SKID=1: main + skid register per stage, ready is a registered flag.
module reg_slice_chain #(
  parameter int unsigned DW     = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned SKID   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          up_valid,
  input  logic [DW-1:0]                 up_data,
  output logic                          up_ready,
  output logic                          down_valid,
  output logic [DW-1:0]                 down_data,
  input  logic                          down_ready,
  output logic [$clog2(2*STAGES+1)-1:0] occupancy
);

  localparam int unsigned OW   = $clog2(2*STAGES+1);
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] mv_q;            // main register valid per stage
  logic [DW-1:0]     md_q [STAGES];   // main register payload per stage
  logic [STAGES-1:0] vin;             // valid presented to each stage
  logic [DW-1:0]     din  [STAGES];   // payload presented to each stage
  logic [STAGES:0]   rdy;             // rdy[i]: stage i accepts; rdy[STAGES]: downstream
  logic [STAGES-1:0] load;            // stage i takes the beat on its input this edge
  logic [OW-1:0]     occ_q;
  logic              up_fire;
  logic              dn_fire;

  // Each stage is fed by the main register of the stage before it
  always_comb begin
    vin[0] = up_valid;
    din[0] = up_data;
    for (int unsigned i = 1; i < STAGES; i++) begin
      vin[i] = mv_q[i-1];
      din[i] = md_q[i-1];
    end
  end

  assign up_ready   = rdy[0] && !clear;
  assign down_valid = mv_q[LAST] && !clear;
  assign down_data  = md_q[LAST];
  assign up_fire    = up_valid && up_ready;
  assign dn_fire    = down_valid && down_ready;
  assign occupancy  = occ_q;

  if (SKID == 0) begin : g_fwd

    // A stage can load when empty or when its own beat moves on this edge
    always_comb begin
      rdy[STAGES] = down_ready && !clear;
      for (int unsigned k = 0; k < STAGES; k++) begin
        rdy[LAST-k] = !mv_q[LAST-k] || rdy[LAST-k+1];
      end
      load = vin & rdy[STAGES-1:0];
    end

    // Valid flags: a ready stage takes whatever valid its input presents
    always_ff @(posedge clk) begin
      if (rst) begin
        mv_q <= '0;
      end else if (clear) begin
        mv_q <= '0;
      end else begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          if (rdy[k]) mv_q[k] <= vin[k];
        end
      end
    end

    // Payload registers change only when a beat is loaded
    always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) md_q[k] <= din[k];
      end
    end

  end else begin : g_skid

    logic [STAGES-1:0] sv_q;            // skid register valid per stage
    logic [DW-1:0]     sd_q [STAGES];   // skid register payload per stage
    logic [STAGES-1:0] mfree;           // main register may be overwritten this edge

    // Ready is the inverse of the registered skid flag, so down_ready never reaches up_ready
    always_comb begin
      rdy[STAGES] = down_ready && !clear;
      for (int unsigned k = 0; k < STAGES; k++) begin
        rdy[k] = !sv_q[k];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        mfree[k] = !mv_q[k] || rdy[k+1];
      end
      load = vin & rdy[STAGES-1:0];
    end

    // Flags: main refills from skid first; skid only catches a beat while main is stuck
    always_ff @(posedge clk) begin
      if (rst) begin
        mv_q <= '0;
        sv_q <= '0;
      end else if (clear) begin
        mv_q <= '0;
        sv_q <= '0;
      end else begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          if (mfree[k]) begin
            if (sv_q[k]) begin
              mv_q[k] <= 1'b1;
              sv_q[k] <= 1'b0;
            end else begin
              mv_q[k] <= load[k];
            end
          end else if (load[k]) begin
            sv_q[k] <= 1'b1;
          end
        end
      end
    end

    // Payload registers follow the same routing as the flags, without reset
    always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (mfree[k]) begin
          if (sv_q[k])      md_q[k] <= sd_q[k];
          else if (load[k]) md_q[k] <= din[k];
        end else if (load[k]) begin
          sd_q[k] <= din[k];
        end
      end
    end

  end

  // Beats held: +1 per accept, -1 per emit, unchanged when both happen
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (clear) begin
      occ_q <= '0;
    end else if (up_fire && !dn_fire) begin
      occ_q <= occ_q + OW'(1);
    end else if (!up_fire && dn_fire) begin
      occ_q <= occ_q - OW'(1);
    end
  end

endmodule
